// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: data/register widths and MEM-stage FSM encodings.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    localparam logic [0:0] MEM_IDLE = 1'b0;
    localparam logic [0:0] MEM_WAIT = 1'b1;

endpackage

// File: rtl/data_memory.sv
// Synchronous single-port data RAM (DEPTH x 32) with registered read data.
// A same-address read-during-write returns the old word.
module data_memory
    import mips_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // rdata only advances on a read so it holds across pipeline bubbles
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: multi-cycle data-memory access with upstream stall, branch resolve, MEM/WB register.
// Optional misaligned-access trap enabled by defining MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] branch_address,
    input  logic [WORD_W-1:0] alu_result,
    input  logic [WORD_W-1:0] write_data,
    input  logic [REG_W-1:0]  rd,
    input  logic              zeroflag,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    output logic              pc_src,
    output logic [WORD_W-1:0] branch_target,
    output logic              stall,
    output logic [WORD_W-1:0] wb_read_data,
    output logic [WORD_W-1:0] wb_alu_result,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_RegWrite,
    output logic              wb_MemToReg
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    logic [0:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              mem_op;
    logic              is_load;
    logic              misalign;
    logic              complete;
    logic              mem_we;
    logic              mem_re;
    logic              load_q;
    logic [WORD_W-1:0] ram_rdata;
    logic [ADDR_W-1:0] word_idx;
    logic              unused_addr_bits;

    assign pc_src        = Branch & zeroflag;
    assign branch_target = branch_address;

    assign mem_op   = MemRead | MemWrite;
    assign is_load  = MemRead & ~MemWrite;
    assign word_idx = alu_result[ADDR_W+1:2];
    assign unused_addr_bits = ^{alu_result[WORD_W-1:ADDR_W+2], alu_result[1:0]};

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign = mem_op & (alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        complete = 1'b0;
        stall    = 1'b0;
        case (state)
            MEM_IDLE: begin
                if (!mem_op || misalign || (MEM_LATENCY == 1)) begin
                    complete = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (cnt == CNT_LAST) begin
                    complete = 1'b1;
                end else begin
                    stall = 1'b1;
                end
            end
            default: begin
                complete = 1'b0;
                stall    = 1'b0;
            end
        endcase
    end

    // Gating the write with rst drops a pending store when reset lands on its completing cycle
    assign mem_we = complete & ~misalign & MemWrite & ~rst;
    assign mem_re = complete & ~misalign & is_load;

    data_memory #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_data_memory (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (word_idx),
        .wdata (write_data),
        .rdata (ram_rdata)
    );

    // cnt is 0 in IDLE, so cnt+1 also gives the first WAIT count
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= MEM_IDLE;
            cnt           <= '0;
            wb_alu_result <= '0;
            wb_rd         <= '0;
            wb_RegWrite   <= 1'b0;
            wb_MemToReg   <= 1'b0;
            load_q        <= 1'b0;
        end else if (complete) begin
            state         <= MEM_IDLE;
            cnt           <= '0;
            wb_alu_result <= alu_result;
            wb_rd         <= rd;
            wb_RegWrite   <= RegWrite & ~misalign;
            wb_MemToReg   <= MemToReg;
            load_q        <= is_load & ~misalign;
        end else begin
            state         <= MEM_WAIT;
            cnt           <= cnt + CNT_W'(1);
            wb_RegWrite   <= 1'b0;
            wb_MemToReg   <= 1'b0;
        end
    end

    // RAM output register doubles as the MEM/WB load-data stage
    assign wb_read_data = load_q ? ram_rdata : '0;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= complete & misalign;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage at latencies 1, 3 and 4 sharing one stimulus bus.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] branch_address, alu_result, write_data;
    logic [4:0]  rd;
    logic        zeroflag, RegWrite, MemToReg, MemRead, MemWrite, Branch;

    logic        a_pc_src, b_pc_src, c_pc_src;
    logic [31:0] a_branch_target, b_branch_target, c_branch_target;
    logic        a_stall, b_stall, c_stall;
    logic [31:0] a_wb_read_data, b_wb_read_data, c_wb_read_data;
    logic [31:0] a_wb_alu_result, b_wb_alu_result, c_wb_alu_result;
    logic [4:0]  a_wb_rd, b_wb_rd, c_wb_rd;
    logic        a_wb_RegWrite, b_wb_RegWrite, c_wb_RegWrite;
    logic        a_wb_MemToReg, b_wb_MemToReg, c_wb_MemToReg;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        a_trap, b_trap, c_trap;
`endif

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(1024), .ADDR_W(10), .MEM_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .branch_address(branch_address), .alu_result(alu_result),
        .write_data(write_data), .rd(rd), .zeroflag(zeroflag), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .pc_src(a_pc_src), .branch_target(a_branch_target), .stall(a_stall),
        .wb_read_data(a_wb_read_data), .wb_alu_result(a_wb_alu_result), .wb_rd(a_wb_rd),
        .wb_RegWrite(a_wb_RegWrite), .wb_MemToReg(a_wb_MemToReg)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        , .misalign_trap(a_trap)
`endif
    );

    mem_stage #(.DEPTH(1024), .ADDR_W(10), .MEM_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .branch_address(branch_address), .alu_result(alu_result),
        .write_data(write_data), .rd(rd), .zeroflag(zeroflag), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .pc_src(b_pc_src), .branch_target(b_branch_target), .stall(b_stall),
        .wb_read_data(b_wb_read_data), .wb_alu_result(b_wb_alu_result), .wb_rd(b_wb_rd),
        .wb_RegWrite(b_wb_RegWrite), .wb_MemToReg(b_wb_MemToReg)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        , .misalign_trap(b_trap)
`endif
    );

    mem_stage #(.DEPTH(1024), .ADDR_W(10), .MEM_LATENCY(4)) u_lat4 (
        .clk(clk), .rst(rst), .branch_address(branch_address), .alu_result(alu_result),
        .write_data(write_data), .rd(rd), .zeroflag(zeroflag), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .pc_src(c_pc_src), .branch_target(c_branch_target), .stall(c_stall),
        .wb_read_data(c_wb_read_data), .wb_alu_result(c_wb_alu_result), .wb_rd(c_wb_rd),
        .wb_RegWrite(c_wb_RegWrite), .wb_MemToReg(c_wb_MemToReg)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        , .misalign_trap(c_trap)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] r);
        MemRead    = mr;
        MemWrite   = mw;
        RegWrite   = rw;
        MemToReg   = m2r;
        alu_result = addr;
        write_data = wd;
        rd         = r;
    endtask

    task automatic nop();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        Branch         = 1'b0;
        zeroflag       = 1'b0;
        branch_address = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nop();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++; if (a_stall !== 1'b0) $display("FAIL reset_a_stall: got %b want 0", a_stall); else pass_cnt++;
        total_cnt++; if (b_stall !== 1'b0) $display("FAIL reset_b_stall: got %b want 0", b_stall); else pass_cnt++;
        total_cnt++; if (c_stall !== 1'b0) $display("FAIL reset_c_stall: got %b want 0", c_stall); else pass_cnt++;
        total_cnt++; if (a_wb_RegWrite !== 1'b0) $display("FAIL reset_wb_RegWrite: got %b want 0", a_wb_RegWrite); else pass_cnt++;
        total_cnt++; if (b_wb_read_data !== 32'h0) $display("FAIL reset_wb_read_data: got %h want 0", b_wb_read_data); else pass_cnt++;
        total_cnt++; if (c_wb_alu_result !== 32'h0) $display("FAIL reset_wb_alu_result: got %h want 0", c_wb_alu_result); else pass_cnt++;
        total_cnt++; if (c_wb_rd !== 5'd0) $display("FAIL reset_wb_rd: got %0d want 0", c_wb_rd); else pass_cnt++;
    endtask

    task automatic test_single_cycle();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 5'd0);
        #1;
        total_cnt++; if (a_stall !== 1'b0) $display("FAIL lat1_store_stall: got %b want 0", a_stall); else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5);
        #1;
        total_cnt++; if (a_stall !== 1'b0) $display("FAIL lat1_load_stall: got %b want 0", a_stall); else pass_cnt++;
        tick();
        total_cnt++; if (a_wb_read_data !== 32'hDEADBEEF) $display("FAIL lat1_load_data: got %h want deadbeef", a_wb_read_data); else pass_cnt++;
        total_cnt++; if (a_wb_RegWrite !== 1'b1) $display("FAIL lat1_wb_RegWrite: got %b want 1", a_wb_RegWrite); else pass_cnt++;
        total_cnt++; if (a_wb_MemToReg !== 1'b1) $display("FAIL lat1_wb_MemToReg: got %b want 1", a_wb_MemToReg); else pass_cnt++;
        total_cnt++; if (a_wb_rd !== 5'd5) $display("FAIL lat1_wb_rd: got %0d want 5", a_wb_rd); else pass_cnt++;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0, 5'd6);
        tick();
        total_cnt++; if (a_wb_read_data !== 32'h0) $display("FAIL alu_op_read_data: got %h want 0", a_wb_read_data); else pass_cnt++;
        total_cnt++; if (a_wb_alu_result !== 32'h55) $display("FAIL alu_op_alu_result: got %h want 55", a_wb_alu_result); else pass_cnt++;
        total_cnt++; if (a_wb_MemToReg !== 1'b0) $display("FAIL alu_op_MemToReg: got %b want 0", a_wb_MemToReg); else pass_cnt++;
        nop();
    endtask

    task automatic test_multi_cycle_load();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678, 5'd0);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'h0, 5'd7);
        #1;
        total_cnt++; if (b_stall !== 1'b1) $display("FAIL lat3_cyc1_stall: got %b want 1", b_stall); else pass_cnt++;
        tick();
        total_cnt++; if (b_stall !== 1'b1) $display("FAIL lat3_cyc2_stall: got %b want 1", b_stall); else pass_cnt++;
        total_cnt++; if (b_wb_RegWrite !== 1'b0) $display("FAIL lat3_bubble1_RegWrite: got %b want 0", b_wb_RegWrite); else pass_cnt++;
        total_cnt++; if (b_wb_MemToReg !== 1'b0) $display("FAIL lat3_bubble1_MemToReg: got %b want 0", b_wb_MemToReg); else pass_cnt++;
        tick();
        total_cnt++; if (b_stall !== 1'b0) $display("FAIL lat3_cyc3_stall: got %b want 0", b_stall); else pass_cnt++;
        total_cnt++; if (b_wb_RegWrite !== 1'b0) $display("FAIL lat3_bubble2_RegWrite: got %b want 0", b_wb_RegWrite); else pass_cnt++;
        tick();
        total_cnt++; if (b_wb_read_data !== 32'h12345678) $display("FAIL lat3_load_data: got %h want 12345678", b_wb_read_data); else pass_cnt++;
        total_cnt++; if (b_wb_RegWrite !== 1'b1) $display("FAIL lat3_wb_RegWrite: got %b want 1", b_wb_RegWrite); else pass_cnt++;
        total_cnt++; if (b_wb_rd !== 5'd7) $display("FAIL lat3_wb_rd: got %0d want 7", b_wb_rd); else pass_cnt++;
        nop();
    endtask

    task automatic test_branch();
        do_reset();
        Branch = 1'b1; zeroflag = 1'b1; branch_address = 32'h40;
        #1;
        total_cnt++; if (a_pc_src !== 1'b1) $display("FAIL br_taken_pc_src: got %b want 1", a_pc_src); else pass_cnt++;
        total_cnt++; if (a_branch_target !== 32'h40) $display("FAIL br_target: got %h want 40", a_branch_target); else pass_cnt++;
        zeroflag = 1'b0;
        #1;
        total_cnt++; if (a_pc_src !== 1'b0) $display("FAIL br_not_taken_pc_src: got %b want 0", a_pc_src); else pass_cnt++;
        Branch = 1'b0; zeroflag = 1'b1;
        #1;
        total_cnt++; if (a_pc_src !== 1'b0) $display("FAIL no_branch_pc_src: got %b want 0", a_pc_src); else pass_cnt++;
        Branch = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 5'd0);
        #1;
        total_cnt++; if (b_stall !== 1'b1) $display("FAIL br_stall_present: got %b want 1", b_stall); else pass_cnt++;
        total_cnt++; if (b_pc_src !== 1'b1) $display("FAIL br_ungated_by_stall: got %b want 1", b_pc_src); else pass_cnt++;
        nop();
    endtask

    task automatic test_reset_abort();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'hAAAA0001, 5'd0);
        #1;
        total_cnt++; if (c_stall !== 1'b1) $display("FAIL lat4_first_stall: got %b want 1", c_stall); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        total_cnt++; if (c_stall !== 1'b0) $display("FAIL lat4_fourth_stall: got %b want 0", c_stall); else pass_cnt++;
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'hBBBB0002, 5'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nop();
        #1;
        total_cnt++; if (c_stall !== 1'b0) $display("FAIL abort_stall: got %b want 0", c_stall); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 32'h0, 5'd9);
        for (int i = 0; i < 4; i++) tick();
        total_cnt++; if (c_wb_read_data !== 32'hAAAA0001) $display("FAIL abort_store_discarded: got %h want aaaa0001", c_wb_read_data); else pass_cnt++;
        total_cnt++; if (c_wb_RegWrite !== 1'b1) $display("FAIL abort_reload_RegWrite: got %b want 1", c_wb_RegWrite); else pass_cnt++;
        nop();
    endtask

    task automatic test_alias_and_priority();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1008, 32'hCAFEF00D, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 5'd3);
        tick();
        total_cnt++; if (a_wb_read_data !== 32'hCAFEF00D) $display("FAIL alias_load_data: got %h want cafef00d", a_wb_read_data); else pass_cnt++;
        total_cnt++; if (a_wb_alu_result !== 32'h8) $display("FAIL alias_alu_result: got %h want 8", a_wb_alu_result); else pass_cnt++;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'h5A5A5A5A, 5'd4);
        tick();
        total_cnt++; if (a_wb_read_data !== 32'h0) $display("FAIL both_set_no_load: got %h want 0", a_wb_read_data); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h44, 32'h0, 5'd4);
        tick();
        total_cnt++; if (a_wb_read_data !== 32'h5A5A5A5A) $display("FAIL both_set_write_wins: got %h want 5a5a5a5a", a_wb_read_data); else pass_cnt++;
        nop();
    endtask

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    task automatic test_misalign();
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h11112222, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 5'd2);
        #1;
        total_cnt++; if (a_stall !== 1'b0) $display("FAIL trap_a_stall: got %b want 0", a_stall); else pass_cnt++;
        total_cnt++; if (c_stall !== 1'b0) $display("FAIL trap_c_stall: got %b want 0", c_stall); else pass_cnt++;
        tick();
        total_cnt++; if (a_trap !== 1'b1) $display("FAIL trap_pulse: got %b want 1", a_trap); else pass_cnt++;
        total_cnt++; if (a_wb_RegWrite !== 1'b0) $display("FAIL trap_RegWrite: got %b want 0", a_wb_RegWrite); else pass_cnt++;
        total_cnt++; if (a_wb_read_data !== 32'h0) $display("FAIL trap_read_data: got %h want 0", a_wb_read_data); else pass_cnt++;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h12, 32'hFFFFFFFF, 5'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd2);
        tick();
        total_cnt++; if (a_trap !== 1'b0) $display("FAIL trap_one_cycle: got %b want 0", a_trap); else pass_cnt++;
        total_cnt++; if (a_wb_read_data !== 32'h11112222) $display("FAIL trap_mem_unchanged: got %h want 11112222", a_wb_read_data); else pass_cnt++;
        nop();
    endtask
`endif

    initial begin
        rst = 1'b1;
        nop();
        test_reset();
        test_single_cycle();
        test_multi_cycle_load();
        test_branch();
        test_reset_abort();
        test_alias_and_priority();
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        test_misalign();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
